cc_lane_tx: RTL and testbench

//  Transmit side of the gated 8-bit control lane. Accepts one byte plus a direction bit

---
 rtl/cc_lane_tx.sv | 147 ++++++++++++++
 tb/tb_cc_lane_tx.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/cc_lane_tx.sv
// cc_lane_tx: transmit side of the gated 8-bit control lane.
// Captures one byte per handshake and plays out the SETUP -> STROBE -> HOLD
// qualifier sequence with per-bit polarity encoding for the receiver.
module cc_lane_tx #(
    parameter logic [7:0]  INV_MASK      = 8'hF9,
    parameter int unsigned SETUP_CYCLES  = 1,
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES   = 1,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_dir,
    input  logic             abort,
    output logic [7:0]       lane_data,
    output logic             lane_sel,
    output logic             lane_en,
    output logic             lane_gate,
    output logic             lane_dir,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] xfer_count
);

    localparam int unsigned TMR_W = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_STROBE = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    // Timer holds "cycles remaining minus one" for the current phase.
    localparam logic [TMR_W-1:0] SETUP_LOAD  = TMR_W'(SETUP_CYCLES - 1);
    localparam logic [TMR_W-1:0] STROBE_LOAD = TMR_W'(STROBE_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_LOAD   = TMR_W'(HOLD_CYCLES - 1);

    logic [1:0]       state, state_nxt;
    logic [TMR_W-1:0] tmr, tmr_nxt;
    logic             in_ready_nxt;
    logic [7:0]       lane_data_nxt;
    logic             lane_sel_nxt;
    logic             lane_en_nxt;
    logic             lane_gate_nxt;
    logic             lane_dir_nxt;
    logic             done_nxt;
    logic             aborted_nxt;
    logic [CNT_W-1:0] xfer_count_nxt;

    // State, timer and all registered outputs; reset overrides any transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            tmr        <= '0;
            in_ready   <= 1'b0;
            lane_data  <= INV_MASK;
            lane_sel   <= 1'b0;
            lane_en    <= 1'b0;
            lane_gate  <= 1'b0;
            lane_dir   <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            xfer_count <= '0;
        end else begin
            state      <= state_nxt;
            tmr        <= tmr_nxt;
            in_ready   <= in_ready_nxt;
            lane_data  <= lane_data_nxt;
            lane_sel   <= lane_sel_nxt;
            lane_en    <= lane_en_nxt;
            lane_gate  <= lane_gate_nxt;
            lane_dir   <= lane_dir_nxt;
            done       <= done_nxt;
            aborted    <= aborted_nxt;
            xfer_count <= xfer_count_nxt;
        end
    end

    // Next-state and next-output decode for the qualifier sequence.
    always_comb begin
        state_nxt      = state;
        tmr_nxt        = tmr;
        in_ready_nxt   = in_ready;
        lane_data_nxt  = lane_data;
        lane_sel_nxt   = lane_sel;
        lane_en_nxt    = lane_en;
        lane_gate_nxt  = lane_gate;
        lane_dir_nxt   = lane_dir;
        done_nxt       = 1'b0;
        aborted_nxt    = 1'b0;
        xfer_count_nxt = xfer_count;

        case (state)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    lane_data_nxt = in_data ^ INV_MASK;
                    lane_dir_nxt  = in_dir;
                    in_ready_nxt  = 1'b0;
                    lane_sel_nxt  = 1'b1;
                    lane_en_nxt   = 1'b1;
                    tmr_nxt       = SETUP_LOAD;
                    state_nxt     = ST_SETUP;
                end else begin
                    in_ready_nxt = 1'b1;
                end
            end
            ST_SETUP, ST_STROBE, ST_HOLD: begin
                if (abort) begin
                    // Cancel: drop every qualifier and return the lane to idle levels.
                    lane_sel_nxt  = 1'b0;
                    lane_en_nxt   = 1'b0;
                    lane_gate_nxt = 1'b0;
                    lane_data_nxt = INV_MASK;
                    lane_dir_nxt  = 1'b0;
                    in_ready_nxt  = 1'b1;
                    aborted_nxt   = 1'b1;
                    state_nxt     = ST_IDLE;
                end else if (tmr != '0) begin
                    tmr_nxt = tmr - TMR_W'(1);
                end else if (state == ST_SETUP) begin
                    lane_gate_nxt = 1'b1;
                    tmr_nxt       = STROBE_LOAD;
                    state_nxt     = ST_STROBE;
                end else if (state == ST_STROBE) begin
                    lane_gate_nxt = 1'b0;
                    tmr_nxt       = HOLD_LOAD;
                    state_nxt     = ST_HOLD;
                end else begin
                    lane_sel_nxt   = 1'b0;
                    lane_en_nxt    = 1'b0;
                    lane_data_nxt  = INV_MASK;
                    lane_dir_nxt   = 1'b0;
                    in_ready_nxt   = 1'b1;
                    done_nxt       = 1'b1;
                    xfer_count_nxt = xfer_count + CNT_W'(1);
                    state_nxt      = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cc_lane_tx.sv
// Testbench for cc_lane_tx: directed scenarios plus random traffic, checked
// cycle by cycle against a transfer-age reference model.
module tb_cc_lane_tx;

    localparam int unsigned S = 1;
    localparam int unsigned G = 2;
    localparam int unsigned H = 1;
    localparam logic [7:0]  MASK = 8'hF9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_dir = 1'b0;
    logic       abort = 1'b0;

    logic        in_ready, lane_sel, lane_en, lane_gate, lane_dir, done, aborted;
    logic [7:0]  lane_data;
    logic [15:0] xfer_count;

    logic        w_in_ready, w_lane_sel, w_lane_en, w_lane_gate, w_lane_dir, w_done, w_aborted;
    logic [7:0]  w_lane_data;
    logic [1:0]  w_xfer_count;

    cc_lane_tx dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_dir(in_dir), .abort(abort),
        .lane_data(lane_data), .lane_sel(lane_sel), .lane_en(lane_en),
        .lane_gate(lane_gate), .lane_dir(lane_dir), .done(done),
        .aborted(aborted), .xfer_count(xfer_count)
    );

    // Narrow-counter instance sharing the same stimulus, for wrap coverage.
    cc_lane_tx #(.CNT_W(2)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_data(in_data), .in_dir(in_dir), .abort(abort),
        .lane_data(w_lane_data), .lane_sel(w_lane_sel), .lane_en(w_lane_en),
        .lane_gate(w_lane_gate), .lane_dir(w_lane_dir), .done(w_done),
        .aborted(w_aborted), .xfer_count(w_xfer_count)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: a transfer is described by its age k (cycles since accept).
    bit          m_busy = 1'b0;
    int          m_k = 0;
    logic [7:0]  m_data = 8'h00;
    bit          m_dir = 1'b0;
    bit          m_ready = 1'b0;
    bit          m_done = 1'b0;
    bit          m_aborted = 1'b0;
    int unsigned m_count = 0;

    always @(posedge clk) begin
        m_done    = 1'b0;
        m_aborted = 1'b0;
        if (rst) begin
            m_busy  = 1'b0;
            m_ready = 1'b0;
            m_count = 0;
        end else if (m_busy && abort) begin
            m_busy    = 1'b0;
            m_aborted = 1'b1;
            m_ready   = 1'b1;
        end else if (m_busy) begin
            m_k++;
            if (m_k > int'(S + G + H)) begin
                m_busy  = 1'b0;
                m_done  = 1'b1;
                m_count = m_count + 1;
                m_ready = 1'b1;
            end
        end else if (in_valid && m_ready) begin
            m_busy  = 1'b1;
            m_k     = 1;
            m_data  = in_data;
            m_dir   = in_dir;
            m_ready = 1'b0;
        end else begin
            m_ready = 1'b1;
        end
    end

    task automatic check_all();
        logic [7:0] e_data;
        bit         e_gate;
        e_data = m_busy ? (m_data ^ MASK) : MASK;
        e_gate = m_busy && (m_k > int'(S)) && (m_k <= int'(S + G));
        chk("in_ready",   32'(in_ready),   32'(m_ready));
        chk("lane_data",  32'(lane_data),  32'(e_data));
        chk("lane_sel",   32'(lane_sel),   32'(m_busy));
        chk("lane_en",    32'(lane_en),    32'(m_busy));
        chk("lane_gate",  32'(lane_gate),  32'(e_gate));
        chk("lane_dir",   32'(lane_dir),   32'(m_busy && m_dir));
        chk("done",       32'(done),       32'(m_done));
        chk("aborted",    32'(aborted),    32'(m_aborted));
        chk("xfer_count", 32'(xfer_count), m_count % 32'd65536);
        chk("done_abort_excl", 32'(done & aborted), 32'd0);
        chk("w_xfer_count", 32'(w_xfer_count), m_count % 32'd4);
        chk("w_lane_sel",   32'(w_lane_sel),   32'(m_busy));
        chk("w_done",       32'(w_done),       32'(m_done));
    endtask

    // Drive one cycle of inputs, then compare outputs on the falling edge.
    task automatic step(input bit r, input bit v, input logic [7:0] d, input bit dr, input bit a);
        rst = r; in_valid = v; in_data = d; in_dir = dr; abort = a;
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'($urandom), 1'($urandom), 1'b0);
    endtask

    initial begin
        // Reset held two cycles, then release.
        step(1'b1, 1'b1, 8'h55, 1'b1, 1'b0);
        step(1'b1, 1'b1, 8'h55, 1'b1, 1'b0);
        chk("reset_lane_data", 32'(lane_data), 32'h0000_00F9);
        chk("reset_in_ready",  32'(in_ready),  32'd0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("release_ready", 32'(in_ready), 32'd1);

        // Single transfer of 0x00, dir=1.
        step(1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
        chk("single_data", 32'(lane_data), 32'h0000_00F9);
        idle(5);
        chk("single_count", 32'(xfer_count), 32'd1);

        // Encoding.
        step(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
        chk("enc_ff", 32'(lane_data), 32'h0000_0006);
        idle(5);
        step(1'b0, 1'b1, 8'h5A, 1'b0, 1'b0);
        chk("enc_5a", 32'(lane_data), 32'h0000_00A3);
        idle(5);

        // Back-to-back: in_valid held for three accepts.
        for (int i = 0; i < 11; i++) step(1'b0, 1'b1, 8'(i * 37), 1'(i), 1'b0);
        idle(6);
        chk("b2b_count", 32'(xfer_count), 32'd6);

        // Abort in first STROBE cycle.
        step(1'b0, 1'b1, 8'hC3, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("abort_pulse", 32'(aborted), 32'd1);
        chk("abort_gate",  32'(lane_gate), 32'd0);
        idle(2);

        // Abort in IDLE does not block acceptance.
        step(1'b0, 1'b1, 8'h3C, 1'b0, 1'b1);
        chk("idle_abort_accept", 32'(lane_sel), 32'd1);
        idle(6);

        // Reset mid-STROBE.
        step(1'b0, 1'b1, 8'h81, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("rst_mid_sel", 32'(lane_sel), 32'd0);
        idle(3);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            step(1'(($urandom % 200) == 0), 1'(($urandom % 3) != 0), 8'($urandom),
                 1'($urandom), 1'(($urandom % 12) == 0));
        end
        idle(6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
